// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: base opcodes, mnemonic and register enums, and
// the decoded-field bundle used by the encoder (also consumed by the decoder).
package riscv_pkg;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_32    = 7'b0111011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [6:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
    OP_ADDW, OP_SUBW, OP_SLLW, OP_SRLW, OP_SRAW, OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
    OP_ADDIW, OP_SLLIW, OP_SRLIW, OP_SRAIW,
    OP_SB, OP_SH, OP_SW, OP_SD,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR
  } op_e;

  typedef enum logic [4:0] {
    REG_ZERO, REG_RA, REG_SP, REG_GP, REG_TP, REG_T0, REG_T1, REG_T2,
    REG_S0, REG_S1, REG_A0, REG_A1, REG_A2, REG_A3, REG_A4, REG_A5,
    REG_A6, REG_A7, REG_S2, REG_S3, REG_S4, REG_S5, REG_S6, REG_S7,
    REG_S8, REG_S9, REG_S10, REG_S11, REG_T3, REG_T4, REG_T5, REG_T6
  } reg_e;

  typedef enum logic [2:0] { FMT_R, FMT_I, FMT_SH, FMT_SHW, FMT_S, FMT_B, FMT_U, FMT_J } fmt_e;

  typedef struct packed {
    logic       known;
    fmt_e       fmt;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
  } dec_t;

  function automatic dec_t mk_dec(input fmt_e fmt, input logic [6:0] opc,
                                  input logic [2:0] f3, input logic [6:0] f7);
    return '{known: 1'b1, fmt: fmt, opc: opc, f3: f3, f7: f7};
  endfunction

  function automatic logic imm_in_range(input logic [31:0] imm, input int lo, input int hi);
    return ($signed(imm) >= lo) && ($signed(imm) <= hi);
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Two-entry valid/ready buffer; head is presented combinationally from storage
// and reads as zero while empty.
module instr_fifo #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_push;
  logic         w_pop;

  assign in_ready  = (r_count < 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= in_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes one RV64IM request per accepted handshake into a 32-bit word plus an
// illegal flag, buffered through a 2-entry output FIFO; counts illegal requests.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6:0]           in_op,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [31:0]          in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  dec_t                 w_dec;
  logic [31:0]          w_word;
  logic                 w_bad;
  logic                 w_err;
  logic [31:0]          w_instr;
  logic                 w_accept;
  logic [32:0]          w_head;
  logic [ERR_CNT_W-1:0] r_err_count;

  always_comb begin
    w_dec = '{known: 1'b0, fmt: FMT_R, opc: 7'd0, f3: 3'd0, f7: 7'd0};
    case (in_op)
      OP_ADD:    w_dec = mk_dec(FMT_R, OPC_OP, 3'd0, F7_BASE);
      OP_SUB:    w_dec = mk_dec(FMT_R, OPC_OP, 3'd0, F7_ALT);
      OP_SLL:    w_dec = mk_dec(FMT_R, OPC_OP, 3'd1, F7_BASE);
      OP_SLT:    w_dec = mk_dec(FMT_R, OPC_OP, 3'd2, F7_BASE);
      OP_SLTU:   w_dec = mk_dec(FMT_R, OPC_OP, 3'd3, F7_BASE);
      OP_XOR:    w_dec = mk_dec(FMT_R, OPC_OP, 3'd4, F7_BASE);
      OP_SRL:    w_dec = mk_dec(FMT_R, OPC_OP, 3'd5, F7_BASE);
      OP_SRA:    w_dec = mk_dec(FMT_R, OPC_OP, 3'd5, F7_ALT);
      OP_OR:     w_dec = mk_dec(FMT_R, OPC_OP, 3'd6, F7_BASE);
      OP_AND:    w_dec = mk_dec(FMT_R, OPC_OP, 3'd7, F7_BASE);
      OP_MUL:    w_dec = mk_dec(FMT_R, OPC_OP, 3'd0, F7_MULDIV);
      OP_MULH:   w_dec = mk_dec(FMT_R, OPC_OP, 3'd1, F7_MULDIV);
      OP_MULHSU: w_dec = mk_dec(FMT_R, OPC_OP, 3'd2, F7_MULDIV);
      OP_MULHU:  w_dec = mk_dec(FMT_R, OPC_OP, 3'd3, F7_MULDIV);
      OP_DIV:    w_dec = mk_dec(FMT_R, OPC_OP, 3'd4, F7_MULDIV);
      OP_DIVU:   w_dec = mk_dec(FMT_R, OPC_OP, 3'd5, F7_MULDIV);
      OP_REM:    w_dec = mk_dec(FMT_R, OPC_OP, 3'd6, F7_MULDIV);
      OP_REMU:   w_dec = mk_dec(FMT_R, OPC_OP, 3'd7, F7_MULDIV);
      OP_ADDW:   w_dec = mk_dec(FMT_R, OPC_OP_32, 3'd0, F7_BASE);
      OP_SUBW:   w_dec = mk_dec(FMT_R, OPC_OP_32, 3'd0, F7_ALT);
      OP_SLLW:   w_dec = mk_dec(FMT_R, OPC_OP_32, 3'd1, F7_BASE);
      OP_SRLW:   w_dec = mk_dec(FMT_R, OPC_OP_32, 3'd5, F7_BASE);
      OP_SRAW:   w_dec = mk_dec(FMT_R, OPC_OP_32, 3'd5, F7_ALT);
      OP_MULW:   w_dec = mk_dec(FMT_R, OPC_OP_32, 3'd0, F7_MULDIV);
      OP_DIVW:   w_dec = mk_dec(FMT_R, OPC_OP_32, 3'd4, F7_MULDIV);
      OP_DIVUW:  w_dec = mk_dec(FMT_R, OPC_OP_32, 3'd5, F7_MULDIV);
      OP_REMW:   w_dec = mk_dec(FMT_R, OPC_OP_32, 3'd6, F7_MULDIV);
      OP_REMUW:  w_dec = mk_dec(FMT_R, OPC_OP_32, 3'd7, F7_MULDIV);
      OP_ADDI:   w_dec = mk_dec(FMT_I, OPC_OP_IMM, 3'd0, F7_BASE);
      OP_SLTI:   w_dec = mk_dec(FMT_I, OPC_OP_IMM, 3'd2, F7_BASE);
      OP_SLTIU:  w_dec = mk_dec(FMT_I, OPC_OP_IMM, 3'd3, F7_BASE);
      OP_XORI:   w_dec = mk_dec(FMT_I, OPC_OP_IMM, 3'd4, F7_BASE);
      OP_ORI:    w_dec = mk_dec(FMT_I, OPC_OP_IMM, 3'd6, F7_BASE);
      OP_ANDI:   w_dec = mk_dec(FMT_I, OPC_OP_IMM, 3'd7, F7_BASE);
      OP_SLLI:   w_dec = mk_dec(FMT_SH, OPC_OP_IMM, 3'd1, F7_BASE);
      OP_SRLI:   w_dec = mk_dec(FMT_SH, OPC_OP_IMM, 3'd5, F7_BASE);
      OP_SRAI:   w_dec = mk_dec(FMT_SH, OPC_OP_IMM, 3'd5, F7_ALT);
      OP_LB:     w_dec = mk_dec(FMT_I, OPC_LOAD, 3'd0, F7_BASE);
      OP_LH:     w_dec = mk_dec(FMT_I, OPC_LOAD, 3'd1, F7_BASE);
      OP_LW:     w_dec = mk_dec(FMT_I, OPC_LOAD, 3'd2, F7_BASE);
      OP_LD:     w_dec = mk_dec(FMT_I, OPC_LOAD, 3'd3, F7_BASE);
      OP_LBU:    w_dec = mk_dec(FMT_I, OPC_LOAD, 3'd4, F7_BASE);
      OP_LHU:    w_dec = mk_dec(FMT_I, OPC_LOAD, 3'd5, F7_BASE);
      OP_LWU:    w_dec = mk_dec(FMT_I, OPC_LOAD, 3'd6, F7_BASE);
      OP_ADDIW:  w_dec = mk_dec(FMT_I, OPC_OP_IMM32, 3'd0, F7_BASE);
      OP_SLLIW:  w_dec = mk_dec(FMT_SHW, OPC_OP_IMM32, 3'd1, F7_BASE);
      OP_SRLIW:  w_dec = mk_dec(FMT_SHW, OPC_OP_IMM32, 3'd5, F7_BASE);
      OP_SRAIW:  w_dec = mk_dec(FMT_SHW, OPC_OP_IMM32, 3'd5, F7_ALT);
      OP_SB:     w_dec = mk_dec(FMT_S, OPC_STORE, 3'd0, F7_BASE);
      OP_SH:     w_dec = mk_dec(FMT_S, OPC_STORE, 3'd1, F7_BASE);
      OP_SW:     w_dec = mk_dec(FMT_S, OPC_STORE, 3'd2, F7_BASE);
      OP_SD:     w_dec = mk_dec(FMT_S, OPC_STORE, 3'd3, F7_BASE);
      OP_BEQ:    w_dec = mk_dec(FMT_B, OPC_BRANCH, 3'd0, F7_BASE);
      OP_BNE:    w_dec = mk_dec(FMT_B, OPC_BRANCH, 3'd1, F7_BASE);
      OP_BLT:    w_dec = mk_dec(FMT_B, OPC_BRANCH, 3'd4, F7_BASE);
      OP_BGE:    w_dec = mk_dec(FMT_B, OPC_BRANCH, 3'd5, F7_BASE);
      OP_BLTU:   w_dec = mk_dec(FMT_B, OPC_BRANCH, 3'd6, F7_BASE);
      OP_BGEU:   w_dec = mk_dec(FMT_B, OPC_BRANCH, 3'd7, F7_BASE);
      OP_LUI:    w_dec = mk_dec(FMT_U, OPC_LUI, 3'd0, F7_BASE);
      OP_AUIPC:  w_dec = mk_dec(FMT_U, OPC_AUIPC, 3'd0, F7_BASE);
      OP_JAL:    w_dec = mk_dec(FMT_J, OPC_JAL, 3'd0, F7_BASE);
      OP_JALR:   w_dec = mk_dec(FMT_I, OPC_JALR, 3'd0, F7_BASE);
      default:   w_dec.known = 1'b0;
    endcase
  end

  // Shift-immediates put shamt[5] where funct7[0] would sit, hence f7[6:1].
  always_comb begin
    w_word = 32'd0;
    w_bad  = 1'b0;
    case (w_dec.fmt)
      FMT_R: w_word = {w_dec.f7, in_rs2, in_rs1, w_dec.f3, in_rd, w_dec.opc};
      FMT_I: begin
        w_bad  = !imm_in_range(in_imm, -2048, 2047);
        w_word = {in_imm[11:0], in_rs1, w_dec.f3, in_rd, w_dec.opc};
      end
      FMT_SH: begin
        w_bad  = !imm_in_range(in_imm, 0, XLEN - 1);
        w_word = {w_dec.f7[6:1], in_imm[5:0], in_rs1, w_dec.f3, in_rd, w_dec.opc};
      end
      FMT_SHW: begin
        w_bad  = !imm_in_range(in_imm, 0, 31);
        w_word = {w_dec.f7, in_imm[4:0], in_rs1, w_dec.f3, in_rd, w_dec.opc};
      end
      FMT_S: begin
        w_bad  = !imm_in_range(in_imm, -2048, 2047);
        w_word = {in_imm[11:5], in_rs2, in_rs1, w_dec.f3, in_imm[4:0], w_dec.opc};
      end
      FMT_B: begin
        w_bad  = in_imm[0] || !imm_in_range(in_imm, -4096, 4094);
        w_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, w_dec.f3,
                  in_imm[4:1], in_imm[11], w_dec.opc};
      end
      FMT_U: begin
        w_bad  = !imm_in_range(in_imm, 0, 32'h000F_FFFF);
        w_word = {in_imm[19:0], in_rd, w_dec.opc};
      end
      FMT_J: begin
        w_bad  = in_imm[0] || !imm_in_range(in_imm, -1048576, 1048574);
        w_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, w_dec.opc};
      end
      default: w_bad = 1'b1;
    endcase
  end

  assign w_err    = !w_dec.known || w_bad;
  assign w_instr  = w_err ? 32'd0 : w_word;
  assign w_accept = in_valid && in_ready;

  instr_fifo #(.W(33)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({w_instr, w_err}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_head)
  );

  assign out_instr = w_head[32:1];
  assign out_err   = w_head[0];
  assign err_count = r_err_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_count <= '0;
    end else if (w_accept && w_err && (r_err_count != '1)) begin
      r_err_count <= r_err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed and randomized checks of instr_encoder against an arithmetic
// reference encoder and a queue model of the output buffer.
module tb_instr_encoder;
  import riscv_pkg::*;

  localparam int CW = 4;
  localparam int unsigned CMAX = 15;

  localparam logic [7:0] K_R = 8'd0, K_I = 8'd1, K_SH = 8'd2, K_SHW = 8'd3;
  localparam logic [7:0] K_S = 8'd4, K_B = 8'd5, K_U = 8'd6, K_J = 8'd7, K_BAD = 8'd8;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [6:0]    in_op;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [31:0]   in_imm;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic          out_err;
  logic [CW-1:0] err_count;

  int unsigned   n_vec  = 0;
  int unsigned   n_fail = 0;
  logic [32:0]   q[$];
  int unsigned   mcnt = 0;
  int            bnd[16] = '{-2049, -2048, 2047, 2048, -4096, -4098, 4094, 4096,
                             -1048576, 1048574, 1048576, 32'hFFFFF, 32'h100000, 63, 64, 31};

  instr_encoder #(.XLEN(64), .ERR_CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // {kind, opcode, funct3, funct7} for each mnemonic, numbers taken from the ISA manual.
  function automatic logic [31:0] op_info(input logic [6:0] op);
    case (op)
      OP_ADD:    return {K_R, 8'h33, 8'd0, 8'h00};
      OP_SUB:    return {K_R, 8'h33, 8'd0, 8'h20};
      OP_SLL:    return {K_R, 8'h33, 8'd1, 8'h00};
      OP_SLT:    return {K_R, 8'h33, 8'd2, 8'h00};
      OP_SLTU:   return {K_R, 8'h33, 8'd3, 8'h00};
      OP_XOR:    return {K_R, 8'h33, 8'd4, 8'h00};
      OP_SRL:    return {K_R, 8'h33, 8'd5, 8'h00};
      OP_SRA:    return {K_R, 8'h33, 8'd5, 8'h20};
      OP_OR:     return {K_R, 8'h33, 8'd6, 8'h00};
      OP_AND:    return {K_R, 8'h33, 8'd7, 8'h00};
      OP_MUL:    return {K_R, 8'h33, 8'd0, 8'h01};
      OP_MULH:   return {K_R, 8'h33, 8'd1, 8'h01};
      OP_MULHSU: return {K_R, 8'h33, 8'd2, 8'h01};
      OP_MULHU:  return {K_R, 8'h33, 8'd3, 8'h01};
      OP_DIV:    return {K_R, 8'h33, 8'd4, 8'h01};
      OP_DIVU:   return {K_R, 8'h33, 8'd5, 8'h01};
      OP_REM:    return {K_R, 8'h33, 8'd6, 8'h01};
      OP_REMU:   return {K_R, 8'h33, 8'd7, 8'h01};
      OP_ADDW:   return {K_R, 8'h3B, 8'd0, 8'h00};
      OP_SUBW:   return {K_R, 8'h3B, 8'd0, 8'h20};
      OP_SLLW:   return {K_R, 8'h3B, 8'd1, 8'h00};
      OP_SRLW:   return {K_R, 8'h3B, 8'd5, 8'h00};
      OP_SRAW:   return {K_R, 8'h3B, 8'd5, 8'h20};
      OP_MULW:   return {K_R, 8'h3B, 8'd0, 8'h01};
      OP_DIVW:   return {K_R, 8'h3B, 8'd4, 8'h01};
      OP_DIVUW:  return {K_R, 8'h3B, 8'd5, 8'h01};
      OP_REMW:   return {K_R, 8'h3B, 8'd6, 8'h01};
      OP_REMUW:  return {K_R, 8'h3B, 8'd7, 8'h01};
      OP_ADDI:   return {K_I, 8'h13, 8'd0, 8'h00};
      OP_SLTI:   return {K_I, 8'h13, 8'd2, 8'h00};
      OP_SLTIU:  return {K_I, 8'h13, 8'd3, 8'h00};
      OP_XORI:   return {K_I, 8'h13, 8'd4, 8'h00};
      OP_ORI:    return {K_I, 8'h13, 8'd6, 8'h00};
      OP_ANDI:   return {K_I, 8'h13, 8'd7, 8'h00};
      OP_SLLI:   return {K_SH, 8'h13, 8'd1, 8'h00};
      OP_SRLI:   return {K_SH, 8'h13, 8'd5, 8'h00};
      OP_SRAI:   return {K_SH, 8'h13, 8'd5, 8'h20};
      OP_LB:     return {K_I, 8'h03, 8'd0, 8'h00};
      OP_LH:     return {K_I, 8'h03, 8'd1, 8'h00};
      OP_LW:     return {K_I, 8'h03, 8'd2, 8'h00};
      OP_LD:     return {K_I, 8'h03, 8'd3, 8'h00};
      OP_LBU:    return {K_I, 8'h03, 8'd4, 8'h00};
      OP_LHU:    return {K_I, 8'h03, 8'd5, 8'h00};
      OP_LWU:    return {K_I, 8'h03, 8'd6, 8'h00};
      OP_ADDIW:  return {K_I, 8'h1B, 8'd0, 8'h00};
      OP_SLLIW:  return {K_SHW, 8'h1B, 8'd1, 8'h00};
      OP_SRLIW:  return {K_SHW, 8'h1B, 8'd5, 8'h00};
      OP_SRAIW:  return {K_SHW, 8'h1B, 8'd5, 8'h20};
      OP_SB:     return {K_S, 8'h23, 8'd0, 8'h00};
      OP_SH:     return {K_S, 8'h23, 8'd1, 8'h00};
      OP_SW:     return {K_S, 8'h23, 8'd2, 8'h00};
      OP_SD:     return {K_S, 8'h23, 8'd3, 8'h00};
      OP_BEQ:    return {K_B, 8'h63, 8'd0, 8'h00};
      OP_BNE:    return {K_B, 8'h63, 8'd1, 8'h00};
      OP_BLT:    return {K_B, 8'h63, 8'd4, 8'h00};
      OP_BGE:    return {K_B, 8'h63, 8'd5, 8'h00};
      OP_BLTU:   return {K_B, 8'h63, 8'd6, 8'h00};
      OP_BGEU:   return {K_B, 8'h63, 8'd7, 8'h00};
      OP_LUI:    return {K_U, 8'h37, 8'd0, 8'h00};
      OP_AUIPC:  return {K_U, 8'h17, 8'd0, 8'h00};
      OP_JAL:    return {K_J, 8'h6F, 8'd0, 8'h00};
      OP_JALR:   return {K_I, 8'h67, 8'd0, 8'h00};
      default:   return {K_BAD, 24'd0};
    endcase
  endfunction

  // Reference encoder: builds the word by weighted sums of field values.
  function automatic logic [32:0] ref_encode(input logic [6:0] op, input logic [4:0] rd,
                                             input logic [4:0] rs1, input logic [4:0] rs2,
                                             input logic [31:0] imm);
    logic [31:0] inf;
    longint s;
    longint unsigned k, opc, f3, f7, d, a, b, u, w;
    bit ok;
    inf = op_info(op);
    k = 64'(inf[31:24]); opc = 64'(inf[23:16]); f3 = 64'(inf[15:8]); f7 = 64'(inf[7:0]);
    d = 64'(rd); a = 64'(rs1); b = 64'(rs2);
    s = longint'($signed(imm));
    ok = 1'b1;
    w = 0;
    case (k)
      K_R: w = opc + (d << 7) + (f3 << 12) + (a << 15) + (b << 20) + (f7 << 25);
      K_I: begin
        ok = (s >= -2048) && (s <= 2047);
        u = 64'(s) & 64'hFFF;
        w = opc + (d << 7) + (f3 << 12) + (a << 15) + (u << 20);
      end
      K_SH, K_SHW: begin
        ok = (s >= 0) && (s <= ((k == K_SH) ? 63 : 31));
        u = 64'(s) & 64'h3F;
        w = opc + (d << 7) + (f3 << 12) + (a << 15) + (u << 20) + (f7 << 25);
      end
      K_S: begin
        ok = (s >= -2048) && (s <= 2047);
        u = 64'(s) & 64'hFFF;
        w = opc + ((u % 32) << 7) + (f3 << 12) + (a << 15) + (b << 20) + ((u / 32) << 25);
      end
      K_B: begin
        ok = (s % 2 == 0) && (s >= -4096) && (s <= 4094);
        u = 64'(s) & 64'h1FFF;
        w = opc + ((((u / 2) % 16) * 2 + (u / 2048) % 2) << 7) + (f3 << 12) + (a << 15)
            + (b << 20) + (((u / 4096) * 64 + (u / 32) % 64) << 25);
      end
      K_U: begin
        ok = (s >= 0) && (s <= 64'hFFFFF);
        w = opc + (d << 7) + (64'(s) << 12);
      end
      K_J: begin
        ok = (s % 2 == 0) && (s >= -1048576) && (s <= 1048574);
        u = 64'(s) & 64'h1FFFFF;
        w = opc + (d << 7) + (((u / 4096) % 256) << 12) + (((u / 2048) % 2) << 20)
            + (((u / 2) % 1024) << 21) + ((u / 1048576) << 31);
      end
      default: ok = 1'b0;
    endcase
    return ok ? {w[31:0], 1'b0} : {32'd0, 1'b1};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  // One clock: check visible state against the model, step the model with the edge.
  task automatic tick();
    logic acc, pop;
    logic [32:0] e;
    acc = in_valid && (q.size() < 2);
    pop = (q.size() != 0) && out_ready;
    check("in_ready", 32'(in_ready), 32'(q.size() < 2));
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("out_instr", out_instr, q[0][32:1]);
      check("out_err", 32'(out_err), 32'(q[0][0]));
    end
    e = ref_encode(in_op, in_rd, in_rs1, in_rs2, in_imm);
    @(posedge clk); #1;
    if (pop) void'(q.pop_front());
    if (acc) begin
      q.push_back(e);
      if (e[0] && mcnt < CMAX) mcnt++;
    end
    check("err_count", 32'(err_count), mcnt);
  endtask

  task automatic send_chk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [31:0] imm,
                          input logic [31:0] exp_instr, input logic exp_err);
    out_ready = 1'b0;
    drive(op, rd, rs1, rs2, imm);
    tick();
    in_valid = 1'b0;
    check("dir_valid", 32'(out_valid), 32'd1);
    check("dir_instr", out_instr, exp_instr);
    check("dir_err", 32'(out_err), 32'(exp_err));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_op = 7'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_instr", out_instr, 32'd0);
    check("rst_cnt", 32'(err_count), 32'd0);
    reset = 1'b0;

    send_chk(OP_ADD, REG_RA, REG_SP, REG_GP, 32'd0, 32'h003100B3, 1'b0);
    send_chk(OP_ADDI, REG_T0, REG_ZERO, REG_ZERO, 32'hFFFF_FFFF, 32'hFFF00293, 1'b0);
    send_chk(OP_SRAI, REG_RA, REG_RA, REG_ZERO, 32'd3, 32'h4030D093, 1'b0);
    send_chk(OP_BEQ, REG_ZERO, REG_RA, REG_SP, 32'd8, 32'h00208463, 1'b0);
    send_chk(OP_LUI, REG_A0, REG_ZERO, REG_ZERO, 32'h12345, 32'h12345537, 1'b0);

    send_chk(OP_BEQ, REG_ZERO, REG_RA, REG_SP, 32'd3, 32'd0, 1'b1);
    send_chk(OP_ADDI, REG_T0, REG_ZERO, REG_ZERO, 32'd2048, 32'd0, 1'b1);
    check("cnt_two", 32'(err_count), 32'd2);
    for (int i = 0; i < 13; i++) send_chk(7'h7F, 5'd1, 5'd2, 5'd3, 32'd0, 32'd0, 1'b1);
    check("cnt_full", 32'(err_count), 32'd15);
    send_chk(OP_SLLIW, REG_RA, REG_RA, REG_ZERO, 32'd32, 32'd0, 1'b1);
    check("cnt_sat", 32'(err_count), 32'd15);

    // Back-pressure: third request must wait while both slots are held.
    out_ready = 1'b0;
    drive(OP_ADD, REG_RA, REG_SP, REG_GP, 32'd0);        tick();
    drive(OP_ADDI, REG_T0, REG_ZERO, REG_ZERO, 32'hFFFF_FFFF); tick();
    drive(OP_LUI, REG_A0, REG_ZERO, REG_ZERO, 32'h12345);
    check("full_ready", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    check("order0", out_instr, 32'h003100B3);
    tick();
    check("order1", out_instr, 32'hFFF00293);
    tick();
    check("drained", 32'(out_valid), 32'd0);

    // Reset with two words buffered.
    out_ready = 1'b0;
    drive(OP_BEQ, REG_ZERO, REG_RA, REG_SP, 32'd3); tick();
    drive(OP_ADD, REG_RA, REG_SP, REG_GP, 32'd0);   tick();
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_instr", out_instr, 32'd0);
    check("arst_err", 32'(out_err), 32'd0);
    check("arst_cnt", 32'(err_count), 32'd0);
    q.delete(); mcnt = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    drive(OP_ADD, REG_RA, REG_SP, REG_GP, 32'd0); tick();
    in_valid = 1'b0;
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_instr", out_instr, 32'h003100B3);

    for (int i = 0; i < 600; i++) begin
      logic [31:0] imm;
      case ($urandom_range(0, 4))
        0:       imm = 32'($urandom_range(0, 80)) - 32'd16;
        1:       imm = $urandom;
        2:       imm = 32'($urandom_range(0, 32'h100010));
        3:       imm = 32'(bnd[$urandom_range(0, 15)]);
        default: imm = 32'($urandom_range(0, 4200)) - 32'd2100;
      endcase
      drive(7'($urandom_range(0, 69)), 5'($urandom), 5'($urandom), 5'($urandom), imm);
      in_valid  = ($urandom_range(0, 9) < 8);
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter: XLEN, 64, selects shamt limit (63 if 64, 31 if 32) for SLLI/SRLI/SRAI.
REQ-002 SHALL have parameter: ERR_CNT_W, 16, width of saturating error counter.
REQ-003 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: in_valid  input  1  request present.
REQ-006 SHALL have port: in_ready  output  1  request accepted when in_valid&in_ready at rising edge.
REQ-007 SHALL have port: in_op  input  7  mnemonic code (op_e, RV64IM set: R, R-W, I, load, I-W, store, branch, LUI/AUIPC, JAL/JALR).
REQ-008 SHALL have ports: in_rd, in_rs1, in_rs2  input  5 each  register indices.
REQ-009 SHALL have port: in_imm  input  32  signed immediate (byte offset for B/J; raw 20-bit value for U).
REQ-010 SHALL have port: out_valid  output  1  encoded word available.
REQ-011 SHALL have port: out_ready  input  1  consumer takes word when out_valid&out_ready at rising edge.
REQ-012 SHALL have port: out_instr  output  32  encoded RISC-V instruction word.
REQ-013 SHALL have port: out_err  output  1  companion to out_instr; 1 = request illegal.
REQ-014 SHALL have port: err_count  output  ERR_CNT_W  count of illegal requests accepted.

Function
REQ-015 SHALL encode combinationally from accepted request fields and push {instr, err} into a 2-entry output buffer at the accepting edge; latency = 1 cycle (out_valid high the cycle after acceptance when buffer was empty).
REQ-016 SHALL drive in_ready = (occupancy < 2); occupancy 1 with push and pop same edge stays 1; occupancy 2 with pop frees one slot, no push that edge.
REQ-017 SHALL present buffer head on out_instr/out_err, stable while out_valid&!out_ready.
REQ-018 SHALL encode fields per base ISA: opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25]; unused fields zero (e.g., rs2=0 for I-type).
REQ-019 SHALL use immediate layouts: I imm[11:0]->[31:20]; S imm[11:5]->[31:25], imm[4:0]->[11:7]; B imm[12|10:5]->[31:25], imm[4:1|11]->[11:7]; U imm[19:0]->[31:12]; J imm[20|10:1|11|19:12]->[31:12].
REQ-020 SHALL encode shifts-immediate with funct6 000000 (SLLI/SRLI) or 010000 (SRAI) and shamt in [25:20]; W variants use funct7 and 5-bit shamt.
REQ-021 SHALL flag illegal (out_err=1, out_instr=0x00000000): undefined in_op; I/S imm outside -2048..2047; B imm odd or outside -4096..4094; J imm odd or outside -1048576..1048574; U imm outside 0..0xFFFFF; shamt above limit (W: >31).
REQ-022 SHALL increment err_count on each accepted illegal request, saturating at all-ones.
REQ-023 SHALL ignore all inputs when in_valid=0 or in_ready=0 (no state change, no count).

Reset
REQ-024 SHALL, on reset assertion (including mid-transfer), immediately clear buffer: out_valid=0, out_instr=0, out_err=0, err_count=0; in_ready=1 from first edge after deassertion.
REQ-025 SHALL discard any buffered words on reset; no partial output after reset.

Structure
REQ-026 SHALL take opcode constants (0110011, 0111011, 1100111, 0000011, 0010011, 0011011, 0100011, 1100011, 0110111, 0010111, 1101111), op_e enum and register-name enum from shared package riscv_pkg, shared with the decoder.
REQ-027 SHALL instantiate one sub-module instr_fifo (2-entry, 33-bit, valid/ready) for the output buffer; encode logic stays in instr_encoder.

Verification
REQ-028 ADD rd=1 rs1=2 rs2=3 -> out_instr=0x003100B3, out_err=0, one cycle after acceptance.
REQ-029 ADDI rd=5 rs1=0 imm=-1 -> 0xFFF00293; SRAI rd=1 rs1=1 imm=3 -> 0x4030D093.
REQ-030 BEQ rs1=1 rs2=2 imm=8 -> 0x00208463; LUI rd=10 imm=0x12345 -> 0x12345537.
REQ-031 BEQ imm=3, then ADDI imm=2048 -> both out_err=1, out_instr=0, err_count=2; err_count forced-preload all-ones plus one more illegal -> stays all-ones.
REQ-032 out_ready=0, three back-to-back requests -> two accepted, in_ready=0 on third; release out_ready -> words emerge in order, none lost or duplicated.
REQ-033 reset asserted with 2 words buffered -> out_valid=0 and err_count=0 asynchronously; new request after release -> normal 1-cycle latency.
